iq_serializer: RTL and testbench

// - Reverse of the I/Q pair buffer: takes packed 24-bit {I,Q} words and emits them as an

---
 rtl/iq_pkg.sv | 19 +
 rtl/iq_serializer_if.sv | 28 ++
 rtl/iq_word_fifo.sv | 53 +++++
 rtl/iq_serializer.sv | 140 ++++++++++++++
 tb/tb_iq_serializer.sv | 336 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/iq_pkg.sv
// Shared types and constants for the I/Q serializer slice.
package iq_pkg;

    // Default width of one I or Q sample; a packed word is twice this.
    localparam int unsigned DEFAULT_SAMPLE_W = 12;

    // Width of the emitted-pair counter.
    localparam int unsigned PAIR_CNT_W = 16;

    // Q occupies the low half of a packed word; I sits directly above it.
    localparam int unsigned Q_LSB = 0;

    typedef enum logic [1:0] {
        IDLE,
        SEND_I,
        SEND_Q
    } iq_state_t;

endpackage

// File: rtl/iq_serializer_if.sv
// Word-in / sample-out handshake bundle for iq_serializer.
// master = producer + sink side, slave = the serializer.
interface iq_serializer_if
    import iq_pkg::*;
#(
    parameter int unsigned SAMPLE_W = DEFAULT_SAMPLE_W
);

    logic [2*SAMPLE_W-1:0] in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic [SAMPLE_W-1:0]   out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_iq;
    logic [PAIR_CNT_W-1:0] pair_cnt;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_iq, pair_cnt
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_iq, pair_cnt
    );

endinterface

// File: rtl/iq_word_fifo.sv
// Synchronous word FIFO with wrap-bit pointers and a synchronous flush.
// Push when full and pop when empty are ignored; flush beats both.
module iq_word_fifo #(
    parameter int unsigned WIDTH = 24,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    // Same index with opposite wrap bits means the writer has lapped the reader.
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

    // Pointer update; flush returns both pointers to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
        end
    end

    // Storage write; contents need no reset since empty gates every read.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/iq_serializer.sv
// Splits packed {I,Q} words into an interleaved sample stream, I first, one sample per clk.
// Optional feature: define IQSER_PAIR_CNT_EN to count emitted pairs on pair_cnt;
// otherwise pair_cnt is tied to zero.
module iq_serializer
    import iq_pkg::*;
#(
    parameter int unsigned SAMPLE_W = DEFAULT_SAMPLE_W,
    parameter int unsigned DEPTH    = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            sclr,
    iq_serializer_if.slave  bus
);

    localparam int unsigned WORD_W = 2 * SAMPLE_W;

    logic [WORD_W-1:0]   fifo_rdata;
    logic                fifo_full;
    logic                fifo_empty;
    logic                push;
    logic                pop;

    iq_state_t           state_q;
    logic [SAMPLE_W-1:0] q_hold_q;
    logic [SAMPLE_W-1:0] out_data_q;
    logic                out_valid_q;
    logic                out_iq_q;

    // in_ready depends only on registered pointers, never on out_ready.
    assign push         = bus.in_valid && !fifo_full;
    assign bus.in_ready = !fifo_full;

    // Pop whenever a new pair can start: from IDLE, or as the current Q is accepted.
    always_comb begin
        pop = 1'b0;
        if (!sclr && !fifo_empty) begin
            unique case (state_q)
                IDLE:    pop = 1'b1;
                SEND_Q:  pop = bus.out_ready;
                default: pop = 1'b0;
            endcase
        end
    end

    iq_word_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (sclr),
        .push  (push),
        .wdata (bus.in_data),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Sequencer: loads a word's I onto the output and parks its Q until I is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            q_hold_q    <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_iq_q    <= 1'b0;
        end else if (sclr) begin
            state_q     <= IDLE;
            q_hold_q    <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_iq_q    <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (pop) begin
                        state_q     <= SEND_I;
                        out_data_q  <= fifo_rdata[SAMPLE_W +: SAMPLE_W];
                        q_hold_q    <= fifo_rdata[Q_LSB +: SAMPLE_W];
                        out_valid_q <= 1'b1;
                        out_iq_q    <= 1'b0;
                    end
                end
                SEND_I: begin
                    if (bus.out_ready) begin
                        state_q    <= SEND_Q;
                        out_data_q <= q_hold_q;
                        out_iq_q   <= 1'b1;
                    end
                end
                SEND_Q: begin
                    if (bus.out_ready) begin
                        if (pop) begin
                            state_q    <= SEND_I;
                            out_data_q <= fifo_rdata[SAMPLE_W +: SAMPLE_W];
                            q_hold_q   <= fifo_rdata[Q_LSB +: SAMPLE_W];
                            out_iq_q   <= 1'b0;
                        end else begin
                            state_q     <= IDLE;
                            out_valid_q <= 1'b0;
                            out_iq_q    <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_iq    = out_iq_q;

`ifdef IQSER_PAIR_CNT_EN
    localparam logic [PAIR_CNT_W-1:0] CNT_ONE = 1;

    logic [PAIR_CNT_W-1:0] pair_cnt_q;

    // A pair is complete when its Q is accepted; wraps silently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pair_cnt_q <= '0;
        end else if (sclr) begin
            pair_cnt_q <= '0;
        end else if (state_q == SEND_Q && bus.out_ready) begin
            pair_cnt_q <= pair_cnt_q + CNT_ONE;
        end
    end

    assign bus.pair_cnt = pair_cnt_q;
`else
    assign bus.pair_cnt = '0;
`endif

endmodule

// File: tb/tb_iq_serializer.sv
// Self-checking bench for iq_serializer: directed scenarios plus a randomized run
// against a word-queue reference model.
module tb_iq_serializer;
    import iq_pkg::*;

    localparam int unsigned SW    = 12;
    localparam int unsigned DEPTH = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic sclr  = 1'b0;

    iq_serializer_if #(.SAMPLE_W(SW)) bus ();

    iq_serializer #(
        .SAMPLE_W (SW),
        .DEPTH    (DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sclr  (sclr),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;
    int exp_pairs = 0;

    // Reference model: expected samples as {iq, data}, in emission order.
    logic [SW:0] exp_q [$];

    function automatic logic [15:0] pair_exp();
`ifdef IQSER_PAIR_CNT_EN
        return 16'(exp_pairs);
`else
        return 16'd0;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // An accepted word contributes its I then its Q.
    task automatic model_push(input logic [23:0] w);
        exp_q.push_back({1'b0, w[23:12]});
        exp_q.push_back({1'b1, w[11:0]});
    endtask

    task automatic test_reset();
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        rst_n = 1'b0;
        #12;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        n_cmp++; if (bus.out_data !== 12'h000) begin n_fail++; $display("FAIL reset_out_data: got %h want 000", bus.out_data); end
        n_cmp++; if (bus.out_iq !== 1'b0) begin n_fail++; $display("FAIL reset_out_iq: got %b want 0", bus.out_iq); end
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
        n_cmp++; if (bus.pair_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_pair_cnt: got %h want 0", bus.pair_cnt); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        bus.in_data   = 24'hABC123;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL single_in_ready: got %b want 1", bus.in_ready); end
        tick();  // cycle N+1
        bus.in_valid = 1'b0;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL single_n1_valid: got %b want 0", bus.out_valid); end
        tick();  // cycle N+2
        n_cmp++; if ({bus.out_valid, bus.out_iq, bus.out_data} !== {1'b1, 1'b0, 12'hABC}) begin
            n_fail++; $display("FAIL single_i: got v=%b iq=%b d=%h want v=1 iq=0 d=abc", bus.out_valid, bus.out_iq, bus.out_data);
        end
        tick();  // cycle N+3
        n_cmp++; if ({bus.out_valid, bus.out_iq, bus.out_data} !== {1'b1, 1'b1, 12'h123}) begin
            n_fail++; $display("FAIL single_q: got v=%b iq=%b d=%h want v=1 iq=1 d=123", bus.out_valid, bus.out_iq, bus.out_data);
        end
        tick();  // cycle N+4
        exp_pairs++;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL single_n4_valid: got %b want 0", bus.out_valid); end
        n_cmp++; if (bus.pair_cnt !== pair_exp()) begin n_fail++; $display("FAIL single_pair_cnt: got %0d want %0d", bus.pair_cnt, pair_exp()); end
    endtask

    task automatic test_back_to_back();
        int first = -1;
        int last  = -1;
        int nvalid = 0;
        int k = 0;
        logic [SW:0] e;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (bus.out_valid) begin
                if (first < 0) first = c;
                last = c;
                nvalid++;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL b2b_extra: got iq=%b d=%h want no sample", bus.out_iq, bus.out_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({bus.out_iq, bus.out_data} !== e) begin
                        n_fail++; $display("FAIL b2b_sample: got %h want %h", {bus.out_iq, bus.out_data}, e);
                    end
                    if (e[SW]) exp_pairs++;
                end
            end
            if (c % 2 == 0 && k < 4) begin
                bus.in_valid = 1'b1;
                bus.in_data  = 24'($urandom);
                if (bus.in_ready) begin
                    model_push(bus.in_data);
                    k++;
                end
            end else begin
                bus.in_valid = 1'b0;
            end
            tick();
        end
        bus.in_valid = 1'b0;
        n_cmp++; if (nvalid != 8) begin n_fail++; $display("FAIL b2b_count: got %0d want 8", nvalid); end
        n_cmp++; if (last - first + 1 != 8) begin n_fail++; $display("FAIL b2b_gapless: got span %0d want 8", last - first + 1); end
    endtask

    task automatic test_stall();
        bus.out_ready = 1'b1;
        bus.in_data   = 24'h789123;
        bus.in_valid  = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick();  // I visible and accepted
        n_cmp++; if ({bus.out_iq, bus.out_data} !== {1'b0, 12'h789}) begin
            n_fail++; $display("FAIL stall_i: got iq=%b d=%h want iq=0 d=789", bus.out_iq, bus.out_data);
        end
        tick();  // Q visible
        bus.out_ready = 1'b0;
        n_cmp++; if ({bus.out_valid, bus.out_iq, bus.out_data} !== {1'b1, 1'b1, 12'h123}) begin
            n_fail++; $display("FAIL stall_q: got v=%b iq=%b d=%h want v=1 iq=1 d=123", bus.out_valid, bus.out_iq, bus.out_data);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if ({bus.out_valid, bus.out_iq, bus.out_data} !== {1'b1, 1'b1, 12'h123}) begin
                n_fail++; $display("FAIL stall_hold%0d: got v=%b iq=%b d=%h want v=1 iq=1 d=123", i, bus.out_valid, bus.out_iq, bus.out_data);
            end
        end
        bus.out_ready = 1'b1;
        tick();
        exp_pairs++;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_release: got v=%b want 0", bus.out_valid); end
        n_cmp++; if (bus.pair_cnt !== pair_exp()) begin n_fail++; $display("FAIL stall_pair_cnt: got %0d want %0d", bus.pair_cnt, pair_exp()); end
    endtask

    // One word sits in the hold register, so DEPTH+1 words fit before in_ready drops.
    task automatic test_fill();
        logic [23:0] w [6];
        int idx = 0;
        int nsamp = 0;
        logic [SW:0] e;
        for (int i = 0; i < 6; i++) w[i] = 24'($urandom);
        bus.out_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (idx < 6) begin
                bus.in_valid = 1'b1;
                bus.in_data  = w[idx];
                if (bus.in_ready) begin
                    model_push(w[idx]);
                    idx++;
                end
            end else begin
                bus.in_valid = 1'b0;
            end
            tick();
        end
        n_cmp++; if (idx != DEPTH + 1) begin n_fail++; $display("FAIL fill_accepted: got %0d want %0d", idx, DEPTH + 1); end
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL fill_in_ready: got %b want 0", bus.in_ready); end
        bus.out_ready = 1'b1;
        for (int c = 0; c < 40 && nsamp < 12; c++) begin
            if (bus.out_valid) begin
                nsamp++;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL fill_extra: got iq=%b d=%h want no sample", bus.out_iq, bus.out_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({bus.out_iq, bus.out_data} !== e) begin
                        n_fail++; $display("FAIL fill_sample%0d: got %h want %h", nsamp, {bus.out_iq, bus.out_data}, e);
                    end
                    if (e[SW]) exp_pairs++;
                end
            end
            if (idx < 6) begin
                bus.in_valid = 1'b1;
                bus.in_data  = w[idx];
                if (bus.in_ready) begin
                    model_push(w[idx]);
                    idx++;
                end
            end else begin
                bus.in_valid = 1'b0;
            end
            tick();
        end
        bus.in_valid = 1'b0;
        n_cmp++; if (nsamp != 12) begin n_fail++; $display("FAIL fill_drain: got %0d samples want 12", nsamp); end
        n_cmp++; if (idx != 6) begin n_fail++; $display("FAIL fill_sixth: got %0d accepted want 6", idx); end
    endtask

    task automatic test_sclr();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 24'($urandom);
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        n_cmp++; if ({bus.out_valid, bus.out_iq} !== 2'b11) begin
            n_fail++; $display("FAIL sclr_setup: got v=%b iq=%b want v=1 iq=1", bus.out_valid, bus.out_iq);
        end
        exp_pairs = 0;
        sclr = 1'b1;
        tick();
        sclr = 1'b0;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL sclr_out_valid: got %b want 0", bus.out_valid); end
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL sclr_in_ready: got %b want 1", bus.in_ready); end
        n_cmp++; if (bus.pair_cnt !== pair_exp()) begin n_fail++; $display("FAIL sclr_pair_cnt: got %0d want %0d", bus.pair_cnt, pair_exp()); end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL sclr_empty%0d: got v=%b want 0", i, bus.out_valid); end
        end
    endtask

    task automatic test_random();
        logic        stalled = 1'b0;
        logic [SW+1:0] prev = '0;
        logic [SW:0] e;
        for (int c = 0; c < 600; c++) begin
            if (stalled) begin
                n_cmp++;
                if ({bus.out_valid, bus.out_iq, bus.out_data} !== prev) begin
                    n_fail++; $display("FAIL rand_hold@%0d: got %h want %h", c, {bus.out_valid, bus.out_iq, bus.out_data}, prev);
                end
            end
            bus.out_ready = ($urandom_range(0, 3) != 0);
            if (bus.out_valid && bus.out_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL rand_extra@%0d: got %h want no sample", c, {bus.out_iq, bus.out_data});
                end else begin
                    e = exp_q.pop_front();
                    if ({bus.out_iq, bus.out_data} !== e) begin
                        n_fail++; $display("FAIL rand_sample@%0d: got %h want %h", c, {bus.out_iq, bus.out_data}, e);
                    end
                    if (e[SW]) exp_pairs++;
                end
            end
            stalled = bus.out_valid && !bus.out_ready;
            prev    = {bus.out_valid, bus.out_iq, bus.out_data};
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.in_data  = 24'($urandom);
            if (bus.in_valid && bus.in_ready) model_push(bus.in_data);
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 4 * DEPTH + 10; c++) begin
            if (bus.out_valid) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL drain_extra: got %h want no sample", {bus.out_iq, bus.out_data});
                end else begin
                    e = exp_q.pop_front();
                    if ({bus.out_iq, bus.out_data} !== e) begin
                        n_fail++; $display("FAIL drain_sample: got %h want %h", {bus.out_iq, bus.out_data}, e);
                    end
                    if (e[SW]) exp_pairs++;
                end
            end
            tick();
        end
        n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL rand_left: got %0d pending want 0", exp_q.size()); end
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rand_idle: got v=%b want 0", bus.out_valid); end
        n_cmp++; if (bus.pair_cnt !== pair_exp()) begin n_fail++; $display("FAIL rand_pair_cnt: got %0d want %0d", bus.pair_cnt, pair_exp()); end
    endtask

    task automatic test_async_reset();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 24'h5A5A5A;
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        n_cmp++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL areset_setup: got v=%b want 1", bus.out_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL areset_out_valid: got %b want 0", bus.out_valid); end
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL areset_in_ready: got %b want 1", bus.in_ready); end
        n_cmp++; if (bus.pair_cnt !== 16'd0) begin n_fail++; $display("FAIL areset_pair_cnt: got %0d want 0", bus.pair_cnt); end
        exp_q.delete();
        exp_pairs = 0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_fill();
        test_sclr();
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
